// File: rtl/if_fetch_stage_if.sv
// Instruction-memory port of the fetch stage: request/address out, ready/data back.
// Handshake: imem_req marks imem_addr valid; the access completes in the cycle imem_ready=1, and imem_rdata is valid in that same cycle.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, redirect selection and a RUN/DRAIN FSM that lets an
// in-flight access finish before jumping to a redirect target that arrived mid-access.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hold,
  input  logic                     exc_req,
  input  logic                     jr,
  input  logic [31:0]              jr_target,
  input  logic                     jump,
  input  logic [31:0]              jump_target,
  input  logic                     branch_taken,
  input  logic [31:0]              branch_target,
  if_fetch_stage_if.master         imem,
  output logic [31:0]              ReadInst,
  output logic [31:0]              IF_PC_Plus_4,
  output logic                     ifid_flush,
  output logic                     ifid_hold,
  output logic                     dbg_state
);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] pend_pc, pend_n;
  logic        redir;
  logic [31:0] redir_raw;
  logic [31:0] redir_target;
  logic        fetch_ok;

  assign redir = exc_req | jr | jump | branch_taken;

  // Highest-priority redirect wins; low two bits are cleared to keep fetches word aligned.
  always_comb begin
    redir_raw = branch_target;
    if (exc_req)
      redir_raw = EXC_VECTOR;
    else if (jr)
      redir_raw = jr_target;
    else if (jump)
      redir_raw = jump_target;
    redir_target = redir_raw & ~32'h0000_0003;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      pc      <= RESET_PC;
      pend_pc <= 32'h0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      pend_pc <= pend_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    pend_n  = pend_pc;
    case (state)
      RUN: begin
        if (imem.imem_ready) begin
          if (redir)
            pc_n = redir_target;
          else if (!hold)
            pc_n = pc + 32'd4;
        end else if (redir) begin
          // Access still in flight: park the target until the old word comes back.
          pend_n  = redir_target;
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (redir)
          pend_n = redir_target;
        if (imem.imem_ready) begin
          pc_n    = redir ? redir_target : pend_pc;
          state_n = RUN;
        end
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

  always_comb begin
    fetch_ok       = (state == RUN) && imem.imem_ready;
    ReadInst       = fetch_ok ? imem.imem_rdata : 32'h0;
    IF_PC_Plus_4   = pc + 32'd4;
    ifid_flush     = redir | ~fetch_ok;
    ifid_hold      = hold & ~redir;
    imem.imem_addr = pc;
    imem.imem_req  = ~reset;
    dbg_state      = state;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, hand-written reset/wrap sequences and
// random traffic checked against a queue-based model of the fetch rules.
module tb_if_fetch_stage;
  localparam logic [31:0] RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

  logic        clk;
  logic        reset;
  logic        hold, exc_req, jr, jump, branch_taken;
  logic [31:0] jr_target, jump_target, branch_target;
  logic [31:0] ReadInst, IF_PC_Plus_4;
  logic        ifid_flush, ifid_hold, dbg_state;

  if_fetch_stage_if imem_bus();

  if_fetch_stage #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
    .clk(clk), .reset(reset), .hold(hold), .exc_req(exc_req),
    .jr(jr), .jr_target(jr_target), .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem(imem_bus.master),
    .ReadInst(ReadInst), .IF_PC_Plus_4(IF_PC_Plus_4),
    .ifid_flush(ifid_flush), .ifid_hold(ifid_hold), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        hold, exc, jr, jmp, br, rdy;
    logic [31:0] rdata;
    logic [31:0] e_addr, e_inst;
    logic        e_flush, e_ihold, e_st;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(logic h, logic e, logic j, logic jm, logic b, logic r,
                              logic [31:0] rd, logic [31:0] ea, logic [31:0] ei,
                              logic ef, logic eh, logic es);
    vec_t v;
    v.hold = h; v.exc = e; v.jr = j; v.jmp = jm; v.br = b; v.rdy = r; v.rdata = rd;
    v.e_addr = ea; v.e_inst = ei; v.e_flush = ef; v.e_ihold = eh; v.e_st = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic h, input logic e, input logic j, input logic jm,
                       input logic b, input logic r, input logic [31:0] rd);
    hold = h; exc_req = e; jr = j; jump = jm; branch_taken = b;
    imem_bus.imem_ready = r; imem_bus.imem_rdata = rd;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ea, input logic [31:0] ei,
                         input logic ef, input logic eh, input logic es);
    chk({tag, ".addr"},  imem_bus.imem_addr, ea);
    chk({tag, ".inst"},  ReadInst, ei);
    chk({tag, ".plus4"}, IF_PC_Plus_4, ea + 32'd4);
    chk({tag, ".flush"}, {31'h0, ifid_flush}, {31'h0, ef});
    chk({tag, ".ihold"}, {31'h0, ifid_hold}, {31'h0, eh});
    chk({tag, ".state"}, {31'h0, dbg_state}, {31'h0, es});
    chk({tag, ".req"},   {31'h0, imem_bus.imem_req}, 32'h1);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Reference model: current fetch address plus an optional parked redirect target.
  logic [31:0] m_pc;
  logic [31:0] pend_q[$];

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    jr_target     = 32'h0050_000b;
    jump_target   = 32'h0060_0004;
    branch_target = 32'h0040_0103;

    tbl[0]  = mk(0,0,0,0,0,1, 32'h0040_0000, 32'h0040_0000, 32'h0040_0000, 0,0,0);
    tbl[1]  = mk(0,0,0,0,0,1, 32'h0040_0004, 32'h0040_0004, 32'h0040_0004, 0,0,0);
    tbl[2]  = mk(0,0,0,0,0,1, 32'h0040_0008, 32'h0040_0008, 32'h0040_0008, 0,0,0);
    tbl[3]  = mk(0,0,0,0,0,1, 32'h0040_000c, 32'h0040_000c, 32'h0040_000c, 0,0,0);
    tbl[4]  = mk(0,0,0,0,0,0, 32'hdead_beef, 32'h0040_0010, 32'h0,          1,0,0);
    tbl[5]  = mk(0,0,0,0,0,0, 32'hdead_beef, 32'h0040_0010, 32'h0,          1,0,0);
    tbl[6]  = mk(0,0,0,0,0,1, 32'h0040_0010, 32'h0040_0010, 32'h0040_0010, 0,0,0);
    tbl[7]  = mk(0,0,0,0,0,1, 32'h0040_0014, 32'h0040_0014, 32'h0040_0014, 0,0,0);
    tbl[8]  = mk(0,0,0,0,0,1, 32'h0040_0018, 32'h0040_0018, 32'h0040_0018, 0,0,0);
    tbl[9]  = mk(0,0,0,0,0,1, 32'h0040_001c, 32'h0040_001c, 32'h0040_001c, 0,0,0);
    tbl[10] = mk(1,0,0,0,0,1, 32'h0040_0020, 32'h0040_0020, 32'h0040_0020, 0,1,0);
    tbl[11] = mk(1,0,0,0,0,1, 32'h0040_0020, 32'h0040_0020, 32'h0040_0020, 0,1,0);
    tbl[12] = mk(0,0,0,0,0,1, 32'h0040_0020, 32'h0040_0020, 32'h0040_0020, 0,0,0);
    tbl[13] = mk(0,0,0,0,1,0, 32'hdead_beef, 32'h0040_0024, 32'h0,          1,0,0);
    tbl[14] = mk(0,0,0,0,0,0, 32'hdead_beef, 32'h0040_0024, 32'h0,          1,0,1);
    tbl[15] = mk(0,0,0,0,0,1, 32'hcafe_f00d, 32'h0040_0024, 32'h0,          1,0,1);
    tbl[16] = mk(1,1,1,0,1,1, 32'h0040_0100, 32'h0040_0100, 32'h0040_0100, 1,0,0);
    tbl[17] = mk(0,0,0,0,0,1, 32'h8000_0180, 32'h8000_0180, 32'h8000_0180, 0,0,0);
    tbl[18] = mk(0,0,0,1,0,0, 32'hdead_beef, 32'h8000_0184, 32'h0,          1,0,0);
    tbl[19] = mk(0,0,1,0,0,0, 32'hdead_beef, 32'h8000_0184, 32'h0,          1,0,1);
    tbl[20] = mk(0,0,0,0,0,1, 32'h1234_5678, 32'h8000_0184, 32'h0,          1,0,1);
    tbl[21] = mk(0,0,0,0,0,1, 32'h0050_0008, 32'h0050_0008, 32'h0050_0008, 0,0,0);
    tbl[22] = mk(1,0,0,0,0,0, 32'hdead_beef, 32'h0050_000c, 32'h0,          1,1,0);
    tbl[23] = mk(0,0,0,0,0,1, 32'h0050_000c, 32'h0050_000c, 32'h0050_000c, 0,0,0);

    // Reset state while reset is held.
    #12;
    chk("rst.req",   {31'h0, imem_bus.imem_req}, 32'h0);
    chk("rst.addr",  imem_bus.imem_addr, RESET_PC);
    chk("rst.inst",  ReadInst, 32'h0);
    chk("rst.flush", {31'h0, ifid_flush}, 32'h1);
    chk("rst.ihold", {31'h0, ifid_hold}, 32'h0);
    chk("rst.state", {31'h0, dbg_state}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].hold, tbl[i].exc, tbl[i].jr, tbl[i].jmp, tbl[i].br, tbl[i].rdy, tbl[i].rdata);
      #4;
      chk_all($sformatf("vec%0d", i), tbl[i].e_addr, tbl[i].e_inst,
              tbl[i].e_flush, tbl[i].e_ihold, tbl[i].e_st);
      @(posedge clk); #1;
    end

    // Reset arriving while draining drops the request at once and restarts at RESET_PC.
    drive(0, 0, 0, 0, 1, 0, 32'h0);
    @(posedge clk); #1;
    chk("drain.enter", {31'h0, dbg_state}, 32'h1);
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    #2 reset = 1'b1;
    #1;
    chk("drain.rst.req",   {31'h0, imem_bus.imem_req}, 32'h0);
    chk("drain.rst.state", {31'h0, dbg_state}, 32'h0);
    chk("drain.rst.addr",  imem_bus.imem_addr, RESET_PC);
    @(posedge clk); #1;
    reset = 1'b0;
    #4;
    chk_all("post_rst", RESET_PC, 32'h0, 1, 0, 0);
    @(posedge clk); #1;

    // PC+4 wraps past the top of the address space.
    jump_target = 32'hffff_fffe;
    drive(0, 0, 0, 1, 0, 1, 32'h1111_1111);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 1, 32'h2222_2222);
    #4;
    chk_all("wrap", 32'hffff_fffc, 32'h2222_2222, 0, 0, 0);
    @(posedge clk); #1;
    #4;
    chk("wrap.next", imem_bus.imem_addr, 32'h0);
    @(posedge clk); #1;

    // Random traffic against the model.
    do_reset();
    m_pc = RESET_PC;
    pend_q.delete();
    for (int c = 0; c < 500; c++) begin
      logic h, e, j, jm, b, r, rd_ok, any_redir;
      logic [31:0] rd, tgt, e_inst;
      h  = ($urandom_range(0, 4) == 0);
      e  = ($urandom_range(0, 19) == 0);
      j  = ($urandom_range(0, 11) == 0);
      jm = ($urandom_range(0, 11) == 0);
      b  = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 9) < 7);
      rd = $urandom;
      jr_target     = $urandom;
      jump_target   = ($urandom_range(0, 7) == 0) ? 32'hffff_ffff : $urandom;
      branch_target = $urandom;
      drive(h, e, j, jm, b, r, rd);
      any_redir = e | j | jm | b;
      tgt = e ? EXC_VECTOR : j ? jr_target : jm ? jump_target : branch_target;
      tgt = {tgt[31:2], 2'b00};
      rd_ok  = (pend_q.size() == 0) && r;
      e_inst = rd_ok ? rd : 32'h0;
      #4;
      chk_all($sformatf("rnd%0d", c), m_pc, e_inst, any_redir | ~rd_ok,
              h & ~any_redir, pend_q.size() != 0);
      @(posedge clk); #1;
      if (pend_q.size() != 0) begin
        if (any_redir) begin
          pend_q.delete();
          pend_q.push_back(tgt);
        end
        if (r) m_pc = pend_q.pop_front();
      end else if (r) begin
        if (any_redir)  m_pc = tgt;
        else if (!h)    m_pc = m_pc + 32'd4;
      end else if (any_redir) begin
        pend_q.push_back(tgt);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
